// File: rtl/minterm_reg_bank.sv
// minterm_reg_bank: multi-channel programmable truth-table unit. Each channel looks up the
// shared input vector in its own loadable mask and captures the result in a D- or T-mode
// flip-flop. A saturating counter tracks updates that changed any output bit.
module minterm_reg_bank #(
   parameter int unsigned N_IN = 4,
   parameter int unsigned CHANNELS = 4,
   parameter logic [2**N_IN-1:0] RESET_MASK = 16'h6EEE,
   parameter int unsigned CNT_W = 8,
   localparam int unsigned DEPTH = 2**N_IN,
   localparam int unsigned CFG_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [CFG_W-1:0]    cfg_ch,
   input  logic [DEPTH-1:0]    cfg_mask,
   input  logic                cfg_mode,
   input  logic                in_valid,
   input  logic [N_IN-1:0]     in_vec,
   output logic [CHANNELS-1:0] out_q,
   output logic                out_valid,
   output logic [CNT_W-1:0]    chg_cnt,
   output logic                cfg_err
);

   logic [DEPTH-1:0]    mask_q [CHANNELS];
   logic [CHANNELS-1:0] mode_q;
   logic [CHANNELS-1:0] f;
   logic [CHANNELS-1:0] out_d;
   logic [CNT_W-1:0]    cnt_d;
   logic [CHANNELS-1:0] cfg_sel;
   logic                cfg_bad;

   // Truth-table lookup and next output/counter values; uses the currently stored config.
   always_comb begin
      f       = '0;
      out_d   = out_q;
      cnt_d   = chg_cnt;
      cfg_sel = '0;
      cfg_bad = cfg_we && (32'(cfg_ch) >= CHANNELS);
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
         f[ch]       = mask_q[ch][in_vec];
         cfg_sel[ch] = cfg_we && (32'(cfg_ch) == ch);
         if (in_valid) begin
            out_d[ch] = mode_q[ch] ? (out_q[ch] ^ f[ch]) : f[ch];
         end
      end
      // Saturate rather than wrap.
      if (in_valid && (out_d != out_q) && (chg_cnt != '1)) begin
         cnt_d = chg_cnt + CNT_W'(1);
      end
   end

   // State update: synchronous reset overrides both evaluation and config writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            mask_q[ch] <= RESET_MASK;
         end
         mode_q    <= '0;
         out_q     <= '0;
         out_valid <= 1'b0;
         chg_cnt   <= '0;
         cfg_err   <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_valid <= in_valid;
         chg_cnt   <= cnt_d;
         for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (cfg_sel[ch]) begin
               mask_q[ch] <= cfg_mask;
               mode_q[ch] <= cfg_mode;
            end
         end
         // Sticky until reset; out-of-range writes touch no channel.
         if (cfg_bad) begin
            cfg_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_minterm_reg_bank.sv
// Directed bench for minterm_reg_bank. A 4-channel instance is the main target; a 3-channel
// instance shares the stimulus so that cfg_ch=3 is an out-of-range write for it.
module tb_minterm_reg_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_mask;
   logic        cfg_mode;
   logic        in_valid;
   logic [3:0]  in_vec;
   logic [3:0]  out_q;
   logic        out_valid;
   logic [7:0]  chg_cnt;
   logic        cfg_err;
   logic [2:0]  out_q2;
   logic        out_valid2;
   logic [7:0]  chg_cnt2;
   logic        cfg_err2;

   always #5 clk = ~clk;

   minterm_reg_bank #(.N_IN(4), .CHANNELS(4), .RESET_MASK(16'h6EEE), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mask(cfg_mask),
      .cfg_mode(cfg_mode), .in_valid(in_valid), .in_vec(in_vec), .out_q(out_q),
      .out_valid(out_valid), .chg_cnt(chg_cnt), .cfg_err(cfg_err)
   );

   minterm_reg_bank #(.N_IN(4), .CHANNELS(3), .RESET_MASK(16'h6EEE), .CNT_W(8)) dut3 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mask(cfg_mask),
      .cfg_mode(cfg_mode), .in_valid(in_valid), .in_vec(in_vec), .out_q(out_q2),
      .out_valid(out_valid2), .chg_cnt(chg_cnt2), .cfg_err(cfg_err2)
   );

   typedef struct packed {
      logic [3:0] out;
      logic       valid;
      logic [7:0] cnt;
      logic       err;
      logic [2:0] out2;
      logic [7:0] cnt2;
      logic       err2;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_bad = 0;

   // Reference state
   logic [15:0] m_mask [4];
   logic [3:0]  m_mode;
   logic [3:0]  m_out;
   logic        m_valid;
   logic [7:0]  m_cnt;
   logic        m_err;
   logic [7:0]  m_cnt2;
   logic        m_err2;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, push the predicted result, then pop and compare after the edge.
   task automatic step(input logic rst, input logic we, input logic [1:0] ch,
                       input logic [15:0] mask, input logic mode, input logic iv,
                       input logic [3:0] vec);
      exp_t e;
      logic [3:0] nout;
      reset    = rst;
      cfg_we   = we;
      cfg_ch   = ch;
      cfg_mask = mask;
      cfg_mode = mode;
      in_valid = iv;
      in_vec   = vec;
      for (int i = 0; i < 4; i++) begin
         nout[i] = m_mode[i] ? (m_out[i] ^ m_mask[i][vec]) : m_mask[i][vec];
      end
      if (rst) begin
         for (int i = 0; i < 4; i++) m_mask[i] = 16'h6EEE;
         m_mode = '0; m_out = '0; m_valid = 1'b0; m_cnt = '0; m_err = 1'b0;
         m_cnt2 = '0; m_err2 = 1'b0;
      end else begin
         if (iv) begin
            if ((nout != m_out) && (m_cnt != 8'hFF)) m_cnt++;
            if ((nout[2:0] != m_out[2:0]) && (m_cnt2 != 8'hFF)) m_cnt2++;
            m_out = nout;
         end
         m_valid = iv;
         if (we) begin
            m_mask[ch] = mask;
            m_mode[ch] = mode;
            if (ch == 2'd3) m_err2 = 1'b1;
         end
      end
      e = '{out: m_out, valid: m_valid, cnt: m_cnt, err: m_err, out2: m_out[2:0],
            cnt2: m_cnt2, err2: m_err2};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("out_q", 16'(out_q), 16'(e.out));
      chk("out_valid", 16'(out_valid), 16'(e.valid));
      chk("chg_cnt", 16'(chg_cnt), 16'(e.cnt));
      chk("cfg_err", 16'(cfg_err), 16'(e.err));
      chk("out_q2", 16'(out_q2), 16'(e.out2));
      chk("out_valid2", 16'(out_valid2), 16'(e.valid));
      chk("chg_cnt2", 16'(chg_cnt2), 16'(e.cnt2));
      chk("cfg_err2", 16'(cfg_err2), 16'(e.err2));
   endtask

   initial begin
      logic [15:0] pat;
      pat = 16'h6EEE;
      reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mask = '0; cfg_mode = 1'b0;
      in_valid = 1'b0; in_vec = '0;
      m_mode = '0; m_out = '0; m_valid = 1'b0; m_cnt = '0; m_err = 1'b0;
      m_cnt2 = '0; m_err2 = 1'b0;
      for (int i = 0; i < 4; i++) m_mask[i] = 16'h6EEE;

      // Reset
      step(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 4'd0);
      chk("rst_out", 16'(out_q), 16'h0);

      // Sweep every minterm through the reset table
      for (int v = 0; v < 16; v++) begin
         step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 4'(v));
         chk("sweep_lit", 16'(out_q), 16'({4{pat[v]}}));
         chk("sweep_valid", 16'(out_valid), 16'h1);
      end

      // Channel 1 to T mode with all-ones table: toggles every valid cycle
      step(1'b0, 1'b1, 2'd1, 16'hFFFF, 1'b1, 1'b0, 4'd0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 4'd0);
         chk("toggle_ch1", 16'(out_q[1]), 16'((k % 2) == 0));
         chk("ch0_d_mode", 16'(out_q[0]), 16'h0);
      end

      // Same-edge write and evaluate: old mask applies first
      step(1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b1, 4'd1);
      chk("same_edge_old", 16'(out_q[0]), 16'h1);
      step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 4'd1);
      chk("same_edge_new", 16'(out_q[0]), 16'h0);

      // Idle cycles with a wandering input vector
      step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 4'd5);
      step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 4'd9);
      step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 4'd14);
      chk("idle_valid", 16'(out_valid), 16'h0);

      // Saturation: three T-mode channels toggle every cycle
      for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 2'(c), 16'hFFFF, 1'b1, 1'b0, 4'd0);
      for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 4'd7);
      chk("sat_cnt", 16'(chg_cnt), 16'd255);
      chk("sat_cnt2", 16'(chg_cnt2), 16'd255);

      // cfg_ch=3 is out of range for the 3-channel instance
      step(1'b0, 1'b1, 2'd3, 16'h0000, 1'b0, 1'b0, 4'd0);
      chk("err_set", 16'(cfg_err2), 16'h1);
      chk("err_main_clear", 16'(cfg_err), 16'h0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 4'd2);
      chk("err_sticky", 16'(cfg_err2), 16'h1);

      // Reset with write and valid asserted: both ignored
      step(1'b1, 1'b1, 2'd0, 16'h0000, 1'b1, 1'b1, 4'd1);
      chk("rst2_out", 16'(out_q), 16'h0);
      chk("rst2_err", 16'(cfg_err2), 16'h0);
      step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, 4'd1);
      chk("post_rst_out", 16'(out_q), 16'hF);
      chk("post_rst_out2", 16'(out_q2), 16'h7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
